// File: rtl/switch_debounce_io.sv
// Per-bit switch conditioning: 2-flop sync, tick-sampled debounce, sticky press flags with read-clear.
// Latency raw->sw_out: 2 sync clocks plus (STABLE_SAMPLES-1)*TICK_DIV+1..STABLE_SAMPLES*TICK_DIV clocks; no backpressure.
module switch_debounce_io #(
  parameter int WIDTH          = 16,
  parameter int TICK_DIV       = 50000,
  parameter int STABLE_SAMPLES = 4
) (
  input  logic             clock,
  input  logic             reset_L,
  input  logic [WIDTH-1:0] sw_raw,
  input  logic             clear_edges,
  output logic [WIDTH-1:0] sw_out,
  output logic [WIDTH-1:0] press_flags,
  output logic             changed
);

  localparam int CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HIST_D = STABLE_SAMPLES - 1;
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

  if (TICK_DIV < 2 || TICK_DIV > 65535) begin : g_bad_tick_div
    $error("switch_debounce_io: TICK_DIV out of range 2..65535");
  end
  if (STABLE_SAMPLES < 2 || STABLE_SAMPLES > 8) begin : g_bad_samples
    $error("switch_debounce_io: STABLE_SAMPLES out of range 2..8");
  end

  logic [WIDTH-1:0] sync_meta;
  logic [WIDTH-1:0] sw_sync;

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      sync_meta <= '0;
      sw_sync   <= '0;
    end else begin
      sync_meta <= sw_raw;
      sw_sync   <= sync_meta;
    end
  end

  logic [CNT_W-1:0] tick_cnt;
  logic             tick;

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + CNT_W'(1);
    end
  end

  // Only the previous STABLE_SAMPLES-1 samples are stored; the live sw_sync
  // is the newest entry of the history at the tick edge.
  logic [WIDTH-1:0] hist [HIST_D];

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      for (int k = 0; k < HIST_D; k++) begin
        hist[k] <= '0;
      end
    end else if (tick) begin
      hist[0] <= sw_sync;
      for (int k = 1; k < HIST_D; k++) begin
        hist[k] <= hist[k-1];
      end
    end
  end

  logic [WIDTH-1:0] all_one;
  logic [WIDTH-1:0] all_zero;
  logic [WIDTH-1:0] flip;

  always_comb begin
    all_one  = sw_sync;
    all_zero = ~sw_sync;
    for (int k = 0; k < HIST_D; k++) begin
      all_one  = all_one & hist[k];
      all_zero = all_zero & ~hist[k];
    end
    flip = '0;
    if (tick) begin
      flip = (all_one & ~sw_out) | (all_zero & sw_out);
    end
  end

  // A rise on the clearing edge survives; every other flag is dropped.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      sw_out      <= '0;
      press_flags <= '0;
      changed     <= 1'b0;
    end else begin
      sw_out      <= sw_out ^ flip;
      press_flags <= (clear_edges ? '0 : press_flags) | (flip & ~sw_out);
      changed     <= |flip;
    end
  end

endmodule
